// File: rtl/evr_pkg.sv
// evr_pkg: shared widths and FSM state type for the event receiver trigger map.
package evr_pkg;
   localparam int EVENT_CODE_WIDTH = 8;
   localparam int TABLE_DEPTH = 256;
   typedef enum logic {ST_IDLE, ST_CLEAR} evrState_t;
endpackage

// File: rtl/evr_trigger_stretch.sv
// evr_trigger_stretch: reloadable down-counter holding one trigger line high for STRETCH cycles.
module evr_trigger_stretch #(
   parameter int STRETCH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic active
);
   localparam int W = $clog2(STRETCH + 1);
   logic [W-1:0] count;
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else count <= load ? W'(STRETCH) : (count != '0) ? count - W'(1) : count;
   assign active = count != '0;
endmodule

// File: rtl/evr_event_trigger_map.sv
// evr_event_trigger_map: event code -> trigger mask table with per-line pulse stretching.
// Optional EVR_MATCH_COUNT_EN adds a saturating count of lookups with a nonzero mask.
module evr_event_trigger_map
   import evr_pkg::*;
#(
   parameter int TRIGGER_COUNT = 8,
   parameter int STRETCH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic [EVENT_CODE_WIDTH-1:0] eventCode,
   input  logic eventStrobe,
   input  logic cfgWriteStrobe,
   input  logic [EVENT_CODE_WIDTH-1:0] cfgAddr,
   input  logic [TRIGGER_COUNT-1:0] cfgData,
   input  logic cfgClearStrobe,
   output logic busy,
`ifdef EVR_MATCH_COUNT_EN
   output logic [31:0] matchCount,
`endif
   output logic [TRIGGER_COUNT-1:0] triggers
);
   evrState_t state, nextState;
   logic [EVENT_CODE_WIDTH-1:0] clearAddr;
   logic [TRIGGER_COUNT-1:0] mapTable [TABLE_DEPTH];
   logic [TRIGGER_COUNT-1:0] rdMask;
   logic rdValid;
   logic idle;
   logic wrEn;
   logic [EVENT_CODE_WIDTH-1:0] wrAddr;
   logic [TRIGGER_COUNT-1:0] wrData;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= ST_CLEAR;
      else state <= nextState;
   always_comb
      nextState = cfgClearStrobe ? ST_CLEAR :
                  (state == ST_CLEAR && clearAddr == EVENT_CODE_WIDTH'(TABLE_DEPTH - 1)) ? ST_IDLE : state;
   always_comb begin
      idle = state == ST_IDLE;
      busy = !idle;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         clearAddr <= '0;
         rdValid <= 1'b0;
      end else begin
         clearAddr <= cfgClearStrobe ? '0 : busy ? clearAddr + EVENT_CODE_WIDTH'(1) : clearAddr;
         rdValid <= eventStrobe && idle;
      end
   // The clear sweep owns the single write port; config writes only land while idle.
   always_comb begin
      wrEn = busy || (cfgWriteStrobe && idle);
      wrAddr = busy ? clearAddr : cfgAddr;
      wrData = busy ? '0 : cfgData;
   end
   always_ff @(posedge clk) begin
      if (wrEn) mapTable[wrAddr] <= wrData;
      rdMask <= mapTable[eventCode];
   end
   for (genvar i = 0; i < TRIGGER_COUNT; i++) begin : g_line
      evr_trigger_stretch #(.STRETCH(STRETCH)) u_stretch (
         .clk(clk),
         .reset(reset),
         .load(rdValid && rdMask[i]),
         .active(triggers[i])
      );
   end
`ifdef EVR_MATCH_COUNT_EN
   always_ff @(posedge clk or posedge reset)
      if (reset) matchCount <= '0;
      else if (cfgClearStrobe) matchCount <= '0;
      else if (rdValid && rdMask != '0 && matchCount != '1) matchCount <= matchCount + 32'd1;
`endif
endmodule

// File: tb/tb_evr_event_trigger_map.sv
// tb_evr_event_trigger_map: directed vector table, corner sequences and random traffic vs a cycle-window model.
module tb_evr_event_trigger_map;
   localparam int TC = 8;
   localparam int S = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic eventStrobe = 1'b0, cfgWriteStrobe = 1'b0, cfgClearStrobe = 1'b0;
   logic [7:0] eventCode = '0, cfgAddr = '0;
   logic [TC-1:0] cfgData = '0;
   logic busy;
   logic [TC-1:0] triggers;
`ifdef EVR_MATCH_COUNT_EN
   logic [31:0] matchCount;
`endif

   always #5 clk = ~clk;

   evr_event_trigger_map #(.TRIGGER_COUNT(TC), .STRETCH(S)) dut (
      .clk(clk),
      .reset(reset),
      .eventCode(eventCode),
      .eventStrobe(eventStrobe),
      .cfgWriteStrobe(cfgWriteStrobe),
      .cfgAddr(cfgAddr),
      .cfgData(cfgData),
      .cfgClearStrobe(cfgClearStrobe),
      .busy(busy),
`ifdef EVR_MATCH_COUNT_EN
      .matchCount(matchCount),
`endif
      .triggers(triggers)
   );

   typedef struct {
      logic es;
      logic [7:0] code;
      logic ws;
      logic [7:0] addr;
      logic [TC-1:0] data;
      logic [TC-1:0] expTrig;
   } vec_t;

   int nCmp = 0, nErr = 0;
   int cyc = 0, resetCyc = 0, busyLast = 0, lastClear = 0;
   logic [TC-1:0] refTable [256];
   // evMask[n] = mask returned by the lookup accepted in cycle n (0 if none)
   logic [TC-1:0] evMask [8192];
   vec_t vecs [24];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [TC-1:0] expTrig(int c);
      logic [TC-1:0] m = '0;
      for (int n = c - 1 - S; n <= c - 2; n++) if (n >= resetCyc) m |= evMask[n];
      return m;
   endfunction

   function automatic int expCount(int c);
      int k = 0;
      for (int n = lastClear; n <= c - 2; n++) if (evMask[n] != '0) k++;
      return k;
   endfunction

   task automatic tick(input logic es, input logic [7:0] code, input logic ws, input logic [7:0] addr,
                       input logic [TC-1:0] data, input logic cs);
      bit idle;
      idle = cyc > busyLast;
      eventStrobe = es; eventCode = code; cfgWriteStrobe = ws; cfgAddr = addr; cfgData = data; cfgClearStrobe = cs;
      evMask[cyc] = (es && idle) ? refTable[code] : '0;
      if (ws && idle) refTable[addr] = data;
      if (cs) begin
         busyLast = cyc + 256;
         lastClear = cyc;
         foreach (refTable[a]) refTable[a] = '0;
      end
      @(posedge clk);
      #1;
      cyc++;
      eventStrobe = 0; cfgWriteStrobe = 0; cfgClearStrobe = 0;
      check("triggers", triggers, expTrig(cyc));
      check("busy", busy, cyc <= busyLast);
`ifdef EVR_MATCH_COUNT_EN
      check("matchCount", matchCount, expCount(cyc));
`endif
   endtask

   task automatic idleTick();
      tick(0, 8'h00, 0, 8'h00, '0, 0);
   endtask

   task automatic releaseReset();
      @(posedge clk);
      #1;
      cyc++;
      reset = 0;
      resetCyc = cyc;
      busyLast = cyc + 255;
      lastClear = cyc;
      foreach (refTable[a]) refTable[a] = '0;
   endtask

   task automatic waitBusy(input string name, input int already);
      int n = 0;
      while (busy && n < 400) begin
         n++;
         idleTick();
      end
      check(name, n + already, 256);
   endtask

   initial begin
      foreach (evMask[n]) evMask[n] = '0;
      foreach (refTable[a]) refTable[a] = '0;
      vecs[0]  = '{0, 8'h00, 1, 8'h2A, 8'h05, 8'h00};
      vecs[1]  = '{1, 8'h2A, 0, 8'h00, 8'h00, 8'h00};
      vecs[2]  = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h05};
      vecs[3]  = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h05};
      vecs[4]  = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h05};
      vecs[5]  = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h05};
      vecs[6]  = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
      vecs[7]  = '{1, 8'h2A, 0, 8'h00, 8'h00, 8'h00};
      vecs[8]  = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h05};
      vecs[9]  = '{1, 8'h2A, 0, 8'h00, 8'h00, 8'h05};
      vecs[10] = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h05};
      vecs[11] = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h05};
      vecs[12] = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h05};
      vecs[13] = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h05};
      vecs[14] = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
      vecs[15] = '{0, 8'h00, 1, 8'h10, 8'h01, 8'h00};
      vecs[16] = '{1, 8'h10, 1, 8'h10, 8'h80, 8'h00};
      vecs[17] = '{1, 8'h10, 0, 8'h00, 8'h00, 8'h01};
      vecs[18] = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h81};
      vecs[19] = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h81};
      vecs[20] = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h81};
      vecs[21] = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h80};
      vecs[22] = '{0, 8'h00, 0, 8'h00, 8'h00, 8'h00};
      vecs[23] = '{0, 8'h00, 1, 8'h33, 8'hFF, 8'h00};

      @(posedge clk);
      #1;
      cyc++;
      check("initBusy", busy, 1);
      check("initTriggers", triggers, 0);
      releaseReset();
      waitBusy("busyLenAfterReset", 0);
      tick(1, 8'h2A, 0, 8'h00, '0, 0);
      repeat (5) begin
         idleTick();
         check("clearedLookup", triggers, 0);
      end

      for (int k = 0; k < 24; k++) begin
         tick(vecs[k].es, vecs[k].code, vecs[k].ws, vecs[k].addr, vecs[k].data, 0);
         check($sformatf("vec%0d", k), triggers, vecs[k].expTrig);
      end

      // reset in the middle of an all-lines stretch
      tick(1, 8'h33, 0, 8'h00, '0, 0);
      idleTick();
      idleTick();
      check("preResetTriggers", triggers, 8'hFF);
      #1 reset = 1;
      #1;
      check("resetTriggers", triggers, 0);
      check("resetBusy", busy, 1);
`ifdef EVR_MATCH_COUNT_EN
      check("resetMatchCount", matchCount, 0);
`endif
      releaseReset();
      waitBusy("busyLenAfterMidReset", 0);
      tick(1, 8'h33, 0, 8'h00, '0, 0);
      repeat (5) begin
         idleTick();
         check("postResetLookup", triggers, 0);
      end

      // clear strobe with a mapped code looked up during busy
      tick(0, 8'h00, 1, 8'h2A, 8'h05, 0);
      idleTick();
      tick(0, 8'h00, 0, 8'h00, '0, 1);
      repeat (5) begin
         tick(1, 8'h2A, 0, 8'h00, '0, 0);
         check("lookupDuringClear", triggers, 0);
      end
      waitBusy("busyLenAfterClear", 5);
      tick(1, 8'h2A, 0, 8'h00, '0, 0);
      repeat (5) begin
         idleTick();
         check("postClearLookup", triggers, 0);
      end

      for (int k = 0; k < 1500; k++)
         tick(1'($urandom_range(0, 1)), 8'h20 + 8'($urandom_range(0, 15)),
              $urandom_range(0, 3) == 0, 8'h20 + 8'($urandom_range(0, 15)),
              TC'($urandom), $urandom_range(0, 399) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule

// File: doc/evr_event_trigger_map.md
# evr_event_trigger_map

Maps the decoded event-code stream of the event receiver onto a bank of trigger lines, one per programmable pulse generator. Each incoming event code indexes a 256-entry mapping table whose entry is a trigger bitmask. Every selected trigger is driven high for a fixed stretch so the downstream pulse generators see a clean rising edge. The block sits between the event-stream decoder and the bank of programmable pulse generators, in the event clock domain.

## Interface
- TRIGGER_COUNT, 8, number of trigger outputs (1..32)
- STRETCH, 4, trigger high time in clk cycles (>=1)
- clk  input  1  event clock
- reset  input  1  asynchronous, active-high reset
- eventCode  input  8  decoded event code
- eventStrobe  input  1  eventCode valid this cycle
- cfgWriteStrobe  input  1  write cfgData into table entry cfgAddr
- cfgAddr  input  8  table address (event code)
- cfgData  input  TRIGGER_COUNT  trigger mask for that event code
- cfgClearStrobe  input  1  start a full-table clear
- busy  output  1  table clear in progress
- triggers  output  TRIGGER_COUNT  trigger lines to the pulse generators

## Operation
- Only one clock (clk) and one reset (reset). Reset is asynchronous and active-high. Configuration ports are already synchronous to clk; any domain crossing happens upstream of this block.
- Table: 256 x TRIGGER_COUNT, single-port-write / single-port-read block RAM, read-first. Table contents are not reset by reset.
- State machine states:
  - CLEAR: writes zero to address clearAddr and increments it each cycle. Leaves to IDLE after writing address 255.
  - IDLE: normal lookup.
- Transitions:
  - Reset sends the FSM to CLEAR with clearAddr=0, so the table is always zeroed after reset.
  - cfgClearStrobe in any state sends the FSM to CLEAR with clearAddr=0. A strobe during CLEAR restarts the clear from 0.
- Lookup (IDLE only):
  - eventStrobe registers a read of table[eventCode].
  - The returned mask loads the stretch counter of each set bit to STRETCH.
  - triggers[i] = (counter[i] != 0). Each nonzero counter decrements once per cycle.
- Retrigger while high reloads the counter to STRETCH, extending the pulse. No new edge is produced; this is the required behaviour.
- cfgWriteStrobe in IDLE writes the table. A write to the same address as a simultaneous lookup returns the old mask (read-first).
- cfgWriteStrobe and eventStrobe during CLEAR are ignored. Triggers already stretching finish normally.
- Arithmetic: counter width is clog2(STRETCH+1). Counters never wrap below 0.

## Timing
- Reset values:
  - triggers=0, all counters 0, read pipeline cleared.
  - busy=1 (CLEAR begins immediately after reset).
- Event latency: eventStrobe in cycle N → triggers high from cycle N+2 for exactly STRETCH cycles (through N+1+STRETCH).
- Clear: cfgClearStrobe in cycle N → busy=1 from N+1. Address 255 is written in N+256. busy=0 from N+257.
- Reset asserted mid-clear or mid-stretch: outputs drop immediately (asynchronously). The clear restarts from address 0.
- Back-to-back eventStrobe every cycle is supported with no bubbles.

## Configuration
- EVR_MATCH_COUNT_EN defined:
  - Adds output matchCount[31:0], reset 0.
  - It increments one cycle after every lookup whose mask is nonzero, and saturates at 0xFFFFFFFF.
  - cfgClearStrobe zeroes it.
- EVR_MATCH_COUNT_EN undefined: no counter and no port.

## Structure
- Shared package evr_pkg: EVENT_CODE_WIDTH=8, TABLE_DEPTH=256, FSM state enum {ST_IDLE, ST_CLEAR}.
- One sub-module: evr_trigger_stretch, a per-line reloadable down-counter instantiated TRIGGER_COUNT times.
- Table RAM inferred in the top module.

## Test plan
- Reset, then wait: busy high for 256 cycles. All lookups after that return 0 and triggers stays 0.
- Write cfgAddr=0x2A, cfgData=0x05, then send eventCode=0x2A: triggers=0x05 from N+2 for 4 cycles, then 0x00.
- With the same entry, send eventStrobe at N and N+2: trigger 0 stays high N+2..N+7 with no low gap.
- Write and lookup of address 0x10 in the same cycle, old=0x01 and new=0x80: that lookup yields 0x01 and the next lookup yields 0x80.
- cfgClearStrobe, then eventStrobe with a mapped code during busy: no trigger. After busy falls, that code yields 0.
- Assert reset while triggers=0xFF mid-stretch: triggers=0 immediately, busy=1. With EVR_MATCH_COUNT_EN, matchCount=0.
